run_checker: RTL and testbench

RUN_CHECKER -- requirements
Module: run_checker

---
 rtl/run_checker.sv | 146 ++++++++++++++
 tb/tb_run_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_checker.sv
// run_checker: sequences one test run of a core under test.
// Holds the core in reset, lets it run until halt or a cycle budget expires,
// freezes it, then walks the enabled channels comparing observed against
// expected values and latches a pass/fail verdict.
//
// Handshake: start is a single-cycle request, accepted only when the FSM is
// idle or done; halt is a level sampled only while running. There is no
// ready/valid back-pressure; done is held high until the next accepted start.
module run_checker #(
    parameter int DATA_W          = 64,
    parameter int NUM_CHK         = 8,
    parameter int RST_CYCLES      = 2,
    parameter int MAX_CYCLES      = 50,
    parameter int CNT_W           = 16,
    parameter int TIMEOUT_IS_FAIL = 1,
    localparam int MC_W = $clog2(NUM_CHK + 1),
    localparam int FB_W = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      halt,
    input  logic [NUM_CHK*DATA_W-1:0] obs_data,
    input  logic [NUM_CHK*DATA_W-1:0] exp_data,
    input  logic [NUM_CHK-1:0]        chk_mask,
    output logic                      core_reset,
    output logic                      core_stall,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [MC_W-1:0]           mismatch_count,
    output logic [FB_W-1:0]           first_bad,
    output logic [2:0]                dbg_state
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [FB_W-1:0]  IDX_LAST = FB_W'(NUM_CHK - 1);
    localparam logic [RC_W-1:0]  RC_INIT  = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RC_W-1:0] rst_cnt;
    logic [FB_W-1:0] chk_idx;
    logic            ch_bad;
    logic [MC_W-1:0] mc_nxt;
    logic            verdict_pass;

    assign dbg_state = state;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RST;
            S_RST:   if (rst_cnt == '0) state_nxt = S_RUN;
            S_RUN:   if (halt || (cycle_count == CNT_LAST)) state_nxt = S_CHECK;
            S_CHECK: if (chk_idx == IDX_LAST) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RST;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Compare the currently visited channel and form the verdict for the last one.
    always_comb begin
        ch_bad = 1'b0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (FB_W'(i) == chk_idx) begin
                ch_bad = chk_mask[i] &&
                         (obs_data[i*DATA_W +: DATA_W] != exp_data[i*DATA_W +: DATA_W]);
            end
        end
        if (state != S_CHECK) ch_bad = 1'b0;
        mc_nxt       = mismatch_count + MC_W'(ch_bad);
        verdict_pass = (mc_nxt == '0) && !(timeout && (TIMEOUT_IS_FAIL != 0));
    end

    // State register, registered core controls and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            core_reset     <= 1'b1;
            core_stall     <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            cycle_count    <= '0;
            mismatch_count <= '0;
            first_bad      <= '0;
            rst_cnt        <= '0;
            chk_idx        <= '0;
        end else begin
            state      <= state_nxt;
            core_reset <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
            core_stall <= (state_nxt == S_CHECK) || (state_nxt == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fail           <= 1'b0;
                        timeout        <= 1'b0;
                        cycle_count    <= '0;
                        mismatch_count <= '0;
                        first_bad      <= '0;
                        rst_cnt        <= RC_INIT;
                        chk_idx        <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
                end
                S_RUN: begin
                    // halt in the final budget cycle still counts as a clean halt
                    cycle_count <= cycle_count + 1'b1;
                    if (!halt && (cycle_count == CNT_LAST)) timeout <= 1'b1;
                end
                S_CHECK: begin
                    mismatch_count <= mc_nxt;
                    if (ch_bad && (mismatch_count == '0)) first_bad <= chk_idx;
                    if (chk_idx == IDX_LAST) begin
                        done <= 1'b1;
                        pass <= verdict_pass;
                        fail <= !verdict_pass;
                    end else begin
                        chk_idx <= chk_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_checker.sv
// Testbench for run_checker: randomized runs checked against a reference
// model derived from halt time, budget and per-channel data comparison.
module tb_run_checker;

  localparam int DATA_W     = 64;
  localparam int NUM_CHK    = 8;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 50;
  localparam int CNT_W      = 16;
  localparam int W          = NUM_CHK * DATA_W;
  localparam int MC_W       = $clog2(NUM_CHK + 1);
  localparam int FB_W       = $clog2(NUM_CHK);

  // clock / reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic [W-1:0] obs_data = '0;
  logic [W-1:0] exp_data = '0;
  logic [NUM_CHK-1:0] chk_mask = '0;

  always #5 clk = ~clk;

  logic             core_reset, core_stall, done, pass, fail, timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [MC_W-1:0]  mismatch_count;
  logic [FB_W-1:0]  first_bad;
  logic [2:0]       dbg_state;

  logic             nf_core_reset, nf_core_stall, nf_done, nf_pass, nf_fail, nf_timeout;
  logic [CNT_W-1:0] nf_cycle_count;
  logic [MC_W-1:0]  nf_mismatch_count;
  logic [FB_W-1:0]  nf_first_bad;
  logic [2:0]       nf_dbg_state;

  run_checker #(.DATA_W(DATA_W), .NUM_CHK(NUM_CHK), .RST_CYCLES(RST_CYCLES),
                .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .TIMEOUT_IS_FAIL(1)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .obs_data(obs_data), .exp_data(exp_data), .chk_mask(chk_mask),
    .core_reset(core_reset), .core_stall(core_stall), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .cycle_count(cycle_count),
    .mismatch_count(mismatch_count), .first_bad(first_bad), .dbg_state(dbg_state)
  );

  run_checker #(.DATA_W(DATA_W), .NUM_CHK(NUM_CHK), .RST_CYCLES(RST_CYCLES),
                .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W), .TIMEOUT_IS_FAIL(0)) dut_nf (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .obs_data(obs_data), .exp_data(exp_data), .chk_mask(chk_mask),
    .core_reset(nf_core_reset), .core_stall(nf_core_stall), .done(nf_done),
    .pass(nf_pass), .fail(nf_fail), .timeout(nf_timeout), .cycle_count(nf_cycle_count),
    .mismatch_count(nf_mismatch_count), .first_bad(nf_first_bad), .dbg_state(nf_dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: indices of enabled channels whose data differ, in order
  logic [FB_W-1:0] exp_q[$];

  // Reference model: run length from halt time vs budget, verdict from data.
  task automatic model(input int halt_at, input logic [W-1:0] o, input logic [W-1:0] e,
                       input logic [NUM_CHK-1:0] m, output int n, output bit to,
                       output int mm, output int fb, output bit ps, output bit ps_nf);
    if (halt_at >= 1 && halt_at <= MAX_CYCLES) begin
      n = halt_at; to = 1'b0;
    end else begin
      n = MAX_CYCLES; to = 1'b1;
    end
    exp_q.delete();
    for (int i = 0; i < NUM_CHK; i++)
      if (m[i] && (o[i*DATA_W +: DATA_W] !== e[i*DATA_W +: DATA_W])) exp_q.push_back(FB_W'(i));
    mm = exp_q.size();
    fb = (mm > 0) ? int'(exp_q[0]) : 0;
    ps_nf = (mm == 0);
    ps = ps_nf && !to;
  endtask

  // Driver + checks for one complete run; halt_at = 0 means halt never comes.
  // With noise set, start and halt are also pulsed where they must be ignored.
  task automatic do_run(input string name, input int halt_at, input logic [W-1:0] o,
                        input logic [W-1:0] e, input logic [NUM_CHK-1:0] m, input bit noise);
    int n, mm, fb, lat, rst_hi, stall_hi, run_lo;
    bit to, ps, ps_nf;
    model(halt_at, o, e, m, n, to, mm, fb, ps, ps_nf);
    @(negedge clk);
    obs_data = o; exp_data = e; chk_mask = m; start = 1'b1; halt = 1'b0;
    lat = -1; rst_hi = 0; stall_hi = 0; run_lo = 0;
    for (int t = 1; t <= 400; t++) begin
      @(negedge clk);
      start = 1'b0; halt = 1'b0;
      if (t == 1) begin
        n_tests++;
        if ({done, pass, fail, timeout, cycle_count, mismatch_count, first_bad} !== '0) begin
          n_fail++;
          $display("FAIL %s cleared_in_rst: got done=%0b pass=%0b fail=%0b to=%0b cc=%0d mm=%0d fb=%0d, want all 0",
                   name, done, pass, fail, timeout, cycle_count, mismatch_count, first_bad);
        end
      end
      if (done) begin
        lat = t;
        break;
      end
      if (core_reset) rst_hi++;
      if (core_stall) stall_hi++;
      if (!core_reset && !core_stall) run_lo++;
      if (t - RST_CYCLES == halt_at) halt = 1'b1;
      if (noise && t <= RST_CYCLES + n + NUM_CHK) begin
        if (t > 1 && $urandom_range(0, 3) == 0) start = 1'b1;
        if ((t <= RST_CYCLES || t > RST_CYCLES + n) && $urandom_range(0, 1) == 1) halt = 1'b1;
      end
    end
    n_tests++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL %s done_wait: done never rose within 400 cycles", name);
      return;
    end
    n_tests++;
    if (lat != RST_CYCLES + n + NUM_CHK + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, RST_CYCLES + n + NUM_CHK + 1);
    end
    n_tests++;
    if (rst_hi != RST_CYCLES || run_lo != n || stall_hi != NUM_CHK) begin
      n_fail++;
      $display("FAIL %s phases: got rst=%0d run=%0d stall=%0d want %0d %0d %0d",
               name, rst_hi, run_lo, stall_hi, RST_CYCLES, n, NUM_CHK);
    end
    for (int h = 0; h < 3; h++) begin
      n_tests++;
      if (done !== 1'b1 || cycle_count !== CNT_W'(n) || timeout !== to ||
          pass !== ps || fail !== !ps || core_stall !== 1'b1 || core_reset !== 1'b0) begin
        n_fail++;
        $display("FAIL %s result[%0d]: got done=%0b cc=%0d to=%0b pass=%0b fail=%0b stall=%0b rst=%0b want 1 %0d %0b %0b %0b 1 0",
                 name, h, done, cycle_count, timeout, pass, fail, core_stall, core_reset, n, to, ps, !ps);
      end
      n_tests++;
      if (mismatch_count !== MC_W'(mm) || first_bad !== FB_W'(fb)) begin
        n_fail++;
        $display("FAIL %s mismatch[%0d]: got mm=%0d fb=%0d want mm=%0d fb=%0d",
                 name, h, mismatch_count, first_bad, mm, fb);
      end
      n_tests++;
      if (nf_done !== 1'b1 || nf_pass !== ps_nf || nf_fail !== !ps_nf || nf_timeout !== to) begin
        n_fail++;
        $display("FAIL %s nofail_cfg[%0d]: got done=%0b pass=%0b fail=%0b to=%0b want 1 %0b %0b %0b",
                 name, h, nf_done, nf_pass, nf_fail, nf_timeout, ps_nf, !ps_nf, to);
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic check_reset_values(input string name);
    n_tests++;
    if (core_reset !== 1'b1 || core_stall !== 1'b0 || dbg_state !== 3'd0 ||
        {done, pass, fail, timeout, cycle_count, mismatch_count, first_bad} !== '0) begin
      n_fail++;
      $display("FAIL %s reset_values: got rst=%0b stall=%0b st=%0d done=%0b pass=%0b fail=%0b to=%0b cc=%0d mm=%0d fb=%0d, want rst=1 st=0 rest 0",
               name, core_reset, core_stall, dbg_state, done, pass, fail, timeout,
               cycle_count, mismatch_count, first_bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("test_reset");
    // reset and start together: reset must win
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_reset_values("test_reset_vs_start");
  endtask

  task automatic test_pass_basic();
    logic [W-1:0] d;
    d = rand_data();
    do_run("test_pass_basic", 10, d, d, 8'hFF, 1'b0);
  endtask

  task automatic test_timeout();
    logic [W-1:0] d;
    d = rand_data();
    do_run("test_timeout", 0, d, d, 8'hFF, 1'b0);
  endtask

  task automatic test_mask();
    logic [W-1:0] o, e;
    o = rand_data();
    e = o;
    e[3*DATA_W + 17] = ~e[3*DATA_W + 17];
    e[6*DATA_W + 63] = ~e[6*DATA_W + 63];
    do_run("test_mask_ff", 5, o, e, 8'hFF, 1'b0);
    do_run("test_mask_b7", 5, o, e, 8'hB7, 1'b0);
  endtask

  task automatic test_halt_at_budget();
    logic [W-1:0] o, e;
    o = rand_data();
    e = o;
    e[0] = ~e[0];
    do_run("test_halt_at_budget", MAX_CYCLES, o, e, 8'h01, 1'b0);
    do_run("test_halt_after_budget", MAX_CYCLES + 1, o, o, 8'hFF, 1'b0);
  endtask

  task automatic test_rerun_after_fail();
    logic [W-1:0] o, e;
    o = rand_data();
    e = ~o;
    do_run("test_rerun_fail", 7, o, e, 8'hFF, 1'b0);
    do_run("test_rerun_pass", 4, o, o, 8'hFF, 1'b0);
  endtask

  // Reset pulsed at negedge index at_t after start (run halts at RUN cycle 3).
  task automatic test_reset_mid(input string name, input int at_t, input bit want_stall);
    logic [W-1:0] d;
    d = rand_data();
    @(negedge clk);
    obs_data = d; exp_data = ~d; chk_mask = 8'hFF; start = 1'b1;
    for (int t = 1; t <= at_t; t++) begin
      @(negedge clk);
      start = 1'b0; halt = (t - RST_CYCLES == 3);
    end
    n_tests++;
    if (core_stall !== want_stall || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s position: got stall=%0b done=%0b want stall=%0b done=0",
               name, core_stall, done, want_stall);
    end
    halt = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values(name);
    repeat (2) @(negedge clk);
    check_reset_values({name, "_stay_idle"});
  endtask

  task automatic test_random();
    logic [W-1:0] o, e;
    logic [NUM_CHK-1:0] m;
    int h;
    for (int r = 0; r < 16; r++) begin
      o = rand_data();
      e = o;
      for (int i = 0; i < NUM_CHK; i++)
        if ($urandom_range(0, 2) == 0) e[i*DATA_W + $urandom_range(0, DATA_W - 1)] ^= 1'b1;
      m = NUM_CHK'($urandom());
      h = (r % 4 == 0) ? 0 : $urandom_range(1, MAX_CYCLES + 3);
      do_run($sformatf("test_random_%0d", r), h, o, e, m, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_timeout();
    test_mask();
    test_halt_at_budget();
    test_rerun_after_fail();
    test_reset_mid("test_reset_mid_check", RST_CYCLES + 3 + 1 + 4, 1'b1);
    test_reset_mid("test_reset_mid_run", RST_CYCLES + 2, 1'b0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
